core_dbg_apb_master: RTL and testbench

APB4 requester (master) that turns single debug-register commands from the JTAG debug transport into APB transfers toward the core-debug APB slave.
- Accepts one command at a time over a valid/ready handshake.
- Runs the APB SETUP and ACCESS phases, honouring pready wait states, and stops any transfer that runs too long.
- Returns read data and error status over a response valid/ready handshake.

---
 rtl/core_dbg_apb_master.sv | 180 ++++++++++++++++++
 tb/tb_core_dbg_apb_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dbg_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : core_dbg_apb_master
//  Purpose  : APB4 requester that turns single debug-register commands from
//             the JTAG debug transport into APB transfers, with wait-state
//             handling, a transfer timeout and a response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module core_dbg_apb_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrobe,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter so the
  // declarations stay legal in that case.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
  logic                  cmd_ready_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  rsp_err_nxt;
  logic                  rsp_timeout_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic                  psel_nxt;
  logic                  penable_nxt;
  logic                  pwrite_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic [3:0]            pstrb_nxt;

  // Next-state and next-output decode; every output is registered, so the
  // APB command registers double as the latched copy of the command.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    paddr_nxt       = paddr;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    pwdata_nxt      = pwdata;
    pstrb_nxt       = pstrb;

    case (state)
      ST_IDLE: begin
        cmd_ready_nxt = 1'b1;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        if (cmd_valid && cmd_ready) begin
          state_nxt     = ST_SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          paddr_nxt     = cmd_addr;
          pwrite_nxt    = cmd_wr_rd;
          // Reads never drive write data or strobes onto the bus.
          pwdata_nxt    = cmd_wr_rd ? cmd_wdata : '0;
          pstrb_nxt     = cmd_wr_rd ? cmd_wstrobe : 4'b0000;
        end
      end

      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = (!pwrite && !pslverr) ? prdata : '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          wait_cnt_nxt = wait_cnt + CNT_ONE;
          if (wait_cnt + CNT_ONE == CNT_LIMIT) begin
            // Abort: release the bus and report a timed-out error.
            state_nxt       = ST_RESP;
            psel_nxt        = 1'b0;
            penable_nxt     = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
            rsp_rdata_nxt   = '0;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          wait_cnt_nxt  = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= 4'b0000;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      paddr       <= paddr_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      pstrb       <= pstrb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_dbg_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dbg_apb_master
//  Purpose  : Scoreboard bench for core_dbg_apb_master with a memory-backed
//             APB slave and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_dbg_apb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr_rd;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrobe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [4:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  core_dbg_apb_master #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrobe(cmd_wstrobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          nacc;   // expected ACCESS cycles; 0 = transfer is cut by reset
  } bus_t;

  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  logic [31:0] slave_mem[32];
  logic [31:0] model_mem[32];
  int          slave_waits = 0;
  logic        slave_err   = 1'b0;
  int          hold_rsp    = 0;
  int          checks      = 0;
  int          errors      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Memory-backed APB slave: waits slave_waits ACCESS cycles, then completes.
  // Outside a completing cycle it drives noise on pready/pslverr/prdata.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && psel && penable) begin
        if (acc_cnt >= slave_waits) begin
          pready  = 1'b1;
          pslverr = slave_err;
          prdata  = (!pwrite && !slave_err) ? slave_mem[paddr] : $urandom;
          if (pwrite && !slave_err)
            for (int b = 0; b < 4; b++)
              if (pstrb[b]) slave_mem[paddr][8*b +: 8] = pwdata[8*b +: 8];
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
  end

  // Bus monitor: checks SETUP contents, ACCESS stability and ACCESS length.
  initial begin
    bus_t cur;
    bit   in_xfer;
    int   nacc;
    in_xfer = 0; nacc = 0;
    cur = '{addr: '0, wr: 1'b0, wdata: '0, strb: '0, nacc: 0};
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_xfer = 0;
      end else begin
        if (penable && !psel) chk("penable_without_psel", 1, 0);
        if (psel && !penable) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_setup", 1, 0);
          end else begin
            cur = bus_q.pop_front();
            chk("setup_addr_wr_strb", {paddr, pwrite, pstrb}, {cur.addr, cur.wr, cur.strb});
            chk("setup_pwdata", pwdata, cur.wdata);
            in_xfer = 1; nacc = 0;
          end
        end else if (psel && penable) begin
          nacc++;
          chk("access_stable", {paddr, pwrite, pstrb, pwdata}, {cur.addr, cur.wr, cur.strb, cur.wdata});
        end else if (in_xfer) begin
          in_xfer = 0;
          if (cur.nacc != 0) chk("access_cycles", nacc, cur.nacc);
        end
      end
    end
  end

  // Response monitor: pops one expectation per response, checks latency,
  // fields held while waiting, and drives rsp_ready (random or held low).
  initial begin
    rsp_t exp;
    bit   seen, have;
    int   hold_cnt;
    seen = 0; have = 0; hold_cnt = 0;
    exp = '{rdata: '0, err: 1'b0, to: 1'b0, lat: 0, acc: 0};
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        seen = 0; have = 0; rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
            have = 0;
          end else begin
            exp  = rsp_q.pop_front();
            have = 1;
            chk("rsp_latency", cyc + 1 - exp.acc, exp.lat);
          end
          seen = 1;
          hold_cnt = hold_rsp;
          hold_rsp = 0;
        end
        if (have) begin
          chk("rsp_err_timeout", {rsp_err, rsp_timeout}, {exp.err, exp.to});
          chk("rsp_rdata", rsp_rdata, exp.rdata);
        end
        chk("busy_while_rsp", {cmd_ready, psel}, 2'b00);
        if (hold_cnt > 0) begin
          rsp_ready = 1'b0;
          hold_cnt--;
        end else begin
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        if (rsp_ready) seen = 0;
      end else begin
        rsp_ready = 1'($urandom);
      end
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("idle_wait_expired", 0, 1);
      finish_run();
    end
  endtask

  // Issue one command and push the model's expected bus activity/response.
  task automatic send(input logic wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int w, input logic e, input bit expect_rsp);
    rsp_t r;
    bus_t b;
    int   acc;
    wait_idle();
    slave_waits = w;
    slave_err   = e;
    cmd_valid   = 1'b1;
    cmd_wr_rd   = wr;
    cmd_addr    = a;
    cmd_wdata   = d;
    cmd_wstrobe = s;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
    b.addr  = a;
    b.wr    = wr;
    b.wdata = wr ? d : 32'h0;
    b.strb  = wr ? s : 4'h0;
    r.acc   = acc;
    r.rdata = 32'h0;
    if (TO > 0 && w >= TO) begin
      r.err = 1'b1; r.to = 1'b1; r.lat = 2 + TO; b.nacc = TO;
    end else begin
      r.err = e; r.to = 1'b0; r.lat = 3 + w; b.nacc = w + 1;
      if (!e) begin
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (s[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          r.rdata = model_mem[a];
        end
      end
    end
    if (!expect_rsp) b.nacc = 0;
    bus_q.push_back(b);
    if (expect_rsp) rsp_q.push_back(r);
  endtask

  task automatic wait_rsp_valid();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    finish_run();
  end

  // Main stimulus.
  initial begin
    int guard;
    for (int i = 0; i < 32; i++) begin
      slave_mem[i] = 32'hA5A50000 + i;
      model_mem[i] = 32'hA5A50000 + i;
    end
    slave_mem[8] = 32'h00000123;
    model_mem[8] = 32'h00000123;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr_rd = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrobe = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {cmd_ready, rsp_valid, psel, penable, pwrite, pstrb, rsp_err, rsp_timeout, paddr},
        '0);
    chk("reset_data", {pwdata, rsp_rdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // Directed cases.
    send(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b1);   // zero-wait write
    send(1'b0, 5'h08, 32'h0, 4'h0, 2, 1'b0, 1'b1);          // read, 2 waits
    send(1'b0, 5'h04, 32'h0, 4'hF, 0, 1'b0, 1'b1);          // read back the write
    send(1'b0, 5'h02, 32'h0, 4'h0, 0, 1'b1, 1'b1);          // slave error
    send(1'b0, 5'h03, 32'h0, 4'h0, 1000, 1'b0, 1'b1);       // timeout
    send(1'b1, 5'h05, 32'h11223344, 4'h5, 0, 1'b0, 1'b1);   // recovers after timeout
    send(1'b0, 5'h05, 32'h0, 4'h0, 1, 1'b0, 1'b1);
    send(1'b0, 5'h06, 32'h0, 4'h0, TO - 1, 1'b0, 1'b1);     // just under the limit
    send(1'b1, 5'h06, 32'hCAFEF00D, 4'hF, TO, 1'b0, 1'b1);  // exactly the limit
    send(1'b0, 5'h06, 32'h0, 4'h0, 0, 1'b0, 1'b1);

    // Response backpressure with an ignored second command.
    wait_idle();
    hold_rsp = 10;
    send(1'b0, 5'h08, 32'h0, 4'h0, 1, 1'b0, 1'b1);
    wait_rsp_valid();
    cmd_valid = 1'b1; cmd_wr_rd = 1'b1; cmd_addr = 5'h1F;
    cmd_wdata = 32'hBAD0BAD0; cmd_wstrobe = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("bp_cmd_ignored", {cmd_ready, psel, rsp_valid}, 3'b001);
    end
    cmd_valid = 1'b0;
    guard = 0;
    while (rsp_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_idle_after_rsp", {rsp_valid, cmd_ready}, 2'b01);

    // Reset in the middle of an ACCESS wait state.
    send(1'b0, 5'h10, 32'h0, 4'h0, 1000, 1'b0, 1'b0);
    guard = 0;
    while (!penable && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("in_access_before_reset", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_access", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    slave_waits = 0;
    @(negedge clk);
    chk("ready_after_mid_reset", cmd_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_stale_rsp", rsp_valid, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int   sel, w;
      logic e;
      sel = $urandom_range(0, 9);
      if (sel < 6)       w = $urandom_range(0, 3);
      else if (sel == 6) w = TO - 1;
      else if (sel == 7) w = TO;
      else if (sel == 8) w = TO + 4;
      else               w = 0;
      e = ($urandom_range(0, 5) == 0);
      send(1'($urandom), 5'($urandom), $urandom, 4'($urandom), w, e, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    wait_idle();
    guard = 0;
    while (rsp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    finish_run();
  end

endmodule
`default_nettype wire
